// File: rtl/tdc_interval_stamper.sv
`default_nettype none
// ============================================================================
// Module      : tdc_interval_stamper
// Description : Pairs decoded TDC hits into START/STOP, counts whole clock
//               cycles between them and emits interval = K*NUM + fine_start
//               - fine_stop (tap units) through a show-ahead result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_interval_stamper #(
  parameter int NUM        = 12,
  parameter int FINE_W     = 4,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int OUT_W     = COARSE_W + FINE_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iHit,
  input  logic [FINE_W-1:0] iFine,
  input  logic             iReady,
  output logic             oValid,
  output logic [OUT_W-1:0] oInterval,
  output logic             oOvf,
  output logic             oFull,
  output logic [7:0]       oDropCnt,
  output logic             oBusy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COARSE_W-1:0] K_MAX = '1;
  localparam logic [FINE_W:0]     NUM_F = (FINE_W + 1)'(NUM);
  localparam logic [OUT_W-1:0]    NUM_O = OUT_W'(NUM);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_STOP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COARSE_W-1:0] k_q, k_d;
  logic [FINE_W:0]     fstart_q, fstart_d;
  logic [FINE_W:0]     fine_c;
  logic                res_push_d, res_ovf_d;
  logic [OUT_W-1:0]    res_int_d;
  logic                res_vld_q, res_ovf_q;
  logic [OUT_W-1:0]    res_int_q;

  logic [OUT_W:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          drop_q;
  logic                fifo_full, fifo_pop, push_ok, push_drop;
  logic [OUT_W:0]      head;

  // Codes beyond the last tap cannot be physical; pin them to NUM.
  assign fine_c = ({1'b0, iFine} > NUM_F) ? NUM_F : {1'b0, iFine};

  // State, coarse count and captured START fine code.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      fstart_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      fstart_q <= fstart_d;
    end
  end

  // Next-state logic; k_q holds the K value that applies to the current cycle.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    fstart_d   = fstart_q;
    res_push_d = 1'b0;
    res_ovf_d  = 1'b0;
    if (!iEn) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_START;
        WAIT_START: begin
          if (iHit) begin
            fstart_d = fine_c;
            k_d      = COARSE_W'(1);
            state_d  = WAIT_STOP;
          end
        end
        WAIT_STOP: begin
          if (iHit) begin
            res_push_d = 1'b1;
            state_d    = WAIT_START;
          end else if (k_q == K_MAX) begin
            res_push_d = 1'b1;
            res_ovf_d  = 1'b1;
            state_d    = WAIT_START;
          end else begin
            k_d = k_q + COARSE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // K >= 1 guarantees K*NUM covers fine_stop, so the subtraction cannot wrap.
  assign res_int_d = res_ovf_d ? '1
                   : OUT_W'(k_q) * NUM_O + OUT_W'(fstart_q) - OUT_W'(fine_c);

  // Result register between the arithmetic and the FIFO write port.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      res_vld_q <= 1'b0;
      res_ovf_q <= 1'b0;
      res_int_q <= '0;
    end else begin
      res_vld_q <= res_push_d;
      res_ovf_q <= res_ovf_d;
      res_int_q <= res_int_d;
    end
  end

  assign fifo_full = (cnt_q == DEPTH_C);
  assign fifo_pop  = (cnt_q != '0) && iReady;
  assign push_ok   = res_vld_q && (!fifo_full || fifo_pop);
  assign push_drop = res_vld_q && fifo_full && !fifo_pop;

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok)  wr_q <= wr_q + PTR_W'(1);
      if (fifo_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(fifo_pop);
      if (push_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Storage array; a full-with-pop write lands in the slot being vacated.
  always_ff @(posedge iClk) begin
    if (push_ok) mem_q[wr_q] <= {res_ovf_q, res_int_q};
  end

  assign head      = mem_q[rd_q];
  assign oValid    = (cnt_q != '0);
  assign oInterval = oValid ? head[OUT_W-1:0] : '0;
  assign oOvf      = oValid & head[OUT_W];
  assign oFull     = fifo_full;
  assign oDropCnt  = drop_q;
  assign oBusy     = (state_q == WAIT_STOP);

endmodule
`default_nettype wire

// File: tb/tb_tdc_interval_stamper.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_interval_stamper
// Description : Scoreboard bench for tdc_interval_stamper (default instance
//               plus a COARSE_W=4 instance for coarse timeout cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_interval_stamper;

  localparam int NUM   = 12;
  localparam int OUT_A = 20;
  localparam int OUT_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_a, hit_a, ready_a;
  logic [3:0] fine_a;
  logic valid_a, ovf_a, full_a, busy_a;
  logic [OUT_A-1:0] int_a;
  logic [7:0] drop_a;

  logic en_b, hit_b, ready_b;
  logic [3:0] fine_b;
  logic valid_b, ovf_b, full_b, busy_b;
  logic [OUT_B-1:0] int_b;
  logic [7:0] drop_b;

  tdc_interval_stamper dut_a (
    .iClk(clk), .iRst(rst), .iEn(en_a), .iHit(hit_a), .iFine(fine_a),
    .iReady(ready_a), .oValid(valid_a), .oInterval(int_a), .oOvf(ovf_a),
    .oFull(full_a), .oDropCnt(drop_a), .oBusy(busy_a)
  );

  tdc_interval_stamper #(.COARSE_W(4)) dut_b (
    .iClk(clk), .iRst(rst), .iEn(en_b), .iHit(hit_b), .iFine(fine_b),
    .iReady(ready_b), .oValid(valid_b), .oInterval(int_b), .oOvf(ovf_b),
    .oFull(full_b), .oDropCnt(drop_b), .oBusy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_A:0] q_a [$];
  logic [OUT_B:0] q_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampf(input int f);
    return (f > NUM) ? NUM : f;
  endfunction

  // START with fs, STOP with fe k cycles later; optionally expect a result.
  task automatic send_a(input int fs, input int k, input int fe, input bit expect_it);
    hit_a = 1'b1; fine_a = 4'(fs);
    tick();
    hit_a = 1'b0;
    repeat (k - 1) tick();
    hit_a = 1'b1; fine_a = 4'(fe);
    tick();
    hit_a = 1'b0;
    if (expect_it) q_a.push_back({1'b0, OUT_A'(k * NUM + clampf(fs) - clampf(fe))});
  endtask

  // Scoreboard for the default instance: compare each popped head.
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      chk("a_pending", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) chk("a_head", {11'd0, ovf_a, int_a}, {11'd0, q_a.pop_front()});
    end
  end

  // Scoreboard for the COARSE_W=4 instance.
  always @(negedge clk) begin
    if (!rst && valid_b && ready_b) begin
      chk("b_pending", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) chk("b_head", {23'd0, ovf_b, int_b}, {23'd0, q_b.pop_front()});
    end
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0; hit_a = 1'b0; fine_a = '0; ready_a = 1'b1;
    en_b = 1'b0; hit_b = 1'b0; fine_b = '0; ready_b = 1'b1;
    repeat (2) tick();
    chk("rst_valid", valid_a, 0);
    chk("rst_interval", int_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_busy", busy_a, 0);

    rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
    tick();

    // Basic pair: START 5 at cycle 0, STOP 9 at cycle 3 -> 32, visible at cycle 5.
    hit_a = 1'b1; fine_a = 4'd5;
    tick();
    hit_a = 1'b0;
    chk("t1_busy", busy_a, 1);
    tick(); tick();
    hit_a = 1'b1; fine_a = 4'd9;
    q_a.push_back({1'b0, 20'd32});
    tick();
    hit_a = 1'b0;
    chk("t1_valid_c4", valid_a, 0);
    chk("t1_busy_c4", busy_a, 0);
    tick();
    chk("t1_valid_c5", valid_a, 1);
    chk("t1_interval_c5", int_a, 32);

    // K=1 pairs, clamping, back-to-back pairs and a long interval.
    send_a(15, 1, 0, 1);
    send_a(12, 1, 15, 1);
    send_a(5, 1, 9, 1);
    send_a(3, 1, 0, 1);
    send_a(7, 200, 2, 1);
    repeat (4) tick();
    chk("t2_drained", q_a.size(), 0);

    // Coarse timeout on the narrow instance.
    hit_b = 1'b1; fine_b = 4'd3;
    tick();
    hit_b = 1'b0;
    repeat (14) tick();
    chk("to_busy_k15", busy_b, 1);
    q_b.push_back({1'b1, 8'hFF});
    tick();
    chk("to_valid_early", valid_b, 0);
    chk("to_busy_after", busy_b, 0);
    tick();
    chk("to_valid", valid_b, 1);
    chk("to_ovf", ovf_b, 1);
    // STOP exactly at K=15 is a normal result.
    hit_b = 1'b1; fine_b = 4'd3;
    tick();
    hit_b = 1'b0;
    repeat (14) tick();
    hit_b = 1'b1; fine_b = 4'd0;
    q_b.push_back({1'b0, 8'd183});
    tick();
    hit_b = 1'b0;
    repeat (3) tick();
    chk("to_drained", q_b.size(), 0);

    // Fill the FIFO with the consumer stalled.
    ready_a = 1'b0;
    for (int i = 0; i < 16; i++) send_a(i % 13, 1, 0, 1);
    tick();
    chk("fill_full", full_a, 1);
    chk("fill_drop0", drop_a, 0);
    send_a(4, 1, 0, 0);
    tick();
    chk("fill_drop1", drop_a, 1);
    chk("fill_full17", full_a, 1);
    // Push coinciding with a pop while full.
    hit_a = 1'b1; fine_a = 4'd6;
    tick();
    hit_a = 1'b1; fine_a = 4'd1;
    q_a.push_back({1'b0, 20'd17});
    tick();
    hit_a = 1'b0;
    ready_a = 1'b1;
    tick();
    chk("pp_full", full_a, 1);
    chk("pp_drop", drop_a, 1);
    for (int i = 0; i < 40 && q_a.size() > 0; i++) tick();
    chk("pp_drained", q_a.size(), 0);
    tick();
    chk("pp_empty", valid_a, 0);
    chk("pp_notfull", full_a, 0);

    // Enable dropped between START and STOP.
    hit_a = 1'b1; fine_a = 4'd4;
    tick();
    en_a = 1'b0; hit_a = 1'b1; fine_a = 4'd9;
    tick();
    hit_a = 1'b0; en_a = 1'b1;
    chk("en_busy", busy_a, 0);
    tick();
    send_a(2, 1, 7, 1);
    repeat (3) tick();
    chk("en_drained", q_a.size(), 0);
    chk("en_empty", valid_a, 0);

    // Reset mid-measurement with three entries queued.
    ready_a = 1'b0;
    send_a(1, 2, 0, 1);
    send_a(2, 3, 1, 1);
    send_a(3, 1, 3, 1);
    tick(); tick();
    chk("rm_valid", valid_a, 1);
    hit_a = 1'b1; fine_a = 4'd5;
    tick();
    hit_a = 1'b0;
    tick();
    chk("rm_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("rm_valid0", valid_a, 0);
    chk("rm_interval0", int_a, 0);
    chk("rm_ovf0", ovf_a, 0);
    chk("rm_full0", full_a, 0);
    chk("rm_drop0", drop_a, 0);
    chk("rm_busy0", busy_a, 0);
    q_a.delete();
    tick();
    rst = 1'b0; ready_a = 1'b1;
    tick();
    send_a(6, 5, 11, 1);
    send_a(0, 2, 12, 1);
    repeat (4) tick();
    chk("rm_drained", q_a.size(), 0);
    chk("rm_empty", valid_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
